// File: rtl/fp_align_if.sv
// -----------------------------------------------------------------------------
// fp_align_if
// Handshake and data bundle between the producer of binary32 operand pairs,
// the fp_align_stage, and the significand add/subtract stage downstream.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid & ready are both high. A producer holding valid keeps its data stable
// until that edge; ready never depends combinationally on valid.
//
// Signals:
//   in_valid / in_ready      operand pair handshake
//   in_a, in_b               binary32 operands
//   out_valid / out_ready    aligned result handshake
//   out_exp                  common (larger) effective exponent
//   out_big_sign             sign of larger-magnitude operand
//   out_small_sign           sign of smaller-magnitude operand
//   out_big_mant             larger significand, hidden bit included
//   out_small_mant           aligned smaller significand {24b, G, R, S}
//   out_swap                 B had the larger magnitude
//   out_special              either operand has exponent 0xFF
//
// Modports: slave = the alignment stage, master = the environment around it.
// -----------------------------------------------------------------------------
interface fp_align_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_exp;
  logic        out_big_sign;
  logic        out_small_sign;
  logic [23:0] out_big_mant;
  logic [26:0] out_small_mant;
  logic        out_swap;
  logic        out_special;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_exp, out_big_sign, out_small_sign,
           out_big_mant, out_small_mant, out_swap, out_special
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_exp, out_big_sign, out_small_sign,
           out_big_mant, out_small_mant, out_swap, out_special
  );
endinterface

// File: rtl/fp_align_stage.sv
// -----------------------------------------------------------------------------
// fp_align_stage
// Two-stage exponent-compare / significand-alignment pipeline of the binary32
// adder. Stage 1 unpacks both operands, orders them by magnitude and forms the
// exponent difference. Stage 2 right-shifts the smaller significand with
// guard/round/sticky bits. One result per cycle when downstream is ready.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; discards anything in flight
//   bus   fp_align_if.slave (operand input and aligned result output)
// -----------------------------------------------------------------------------
module fp_align_stage (
  input  logic        clk,
  input  logic        rst,
  fp_align_if.slave   bus
);

  // ---------------------------------------------------------------------------
  // Pipeline control: a stage loads when it is empty or its content leaves.
  // ---------------------------------------------------------------------------
  logic s1_valid_q;
  logic s2_valid_q;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv      = !s2_valid_q || bus.out_ready;
  assign s1_adv      = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: unpack, order, exponent difference
  // ---------------------------------------------------------------------------
  logic [7:0]  ea_raw, eb_raw;
  logic [7:0]  ea_eff, eb_eff;
  logic [23:0] ma, mb;
  logic        s1_swap_d;
  logic        s1_big_sign_d, s1_small_sign_d;
  logic [7:0]  s1_exp_d, s1_small_exp_d;
  logic [23:0] s1_big_mant_d, s1_small_mant_d;
  logic [7:0]  s1_diff_d;
  logic        s1_special_d;

  always_comb begin
    ea_raw = bus.in_a[30:23];
    eb_raw = bus.in_b[30:23];
    // Denormals behave as exponent 1 with no hidden bit.
    ea_eff = (ea_raw == 8'd0) ? 8'd1 : ea_raw;
    eb_eff = (eb_raw == 8'd0) ? 8'd1 : eb_raw;
    ma     = {(ea_raw != 8'd0), bus.in_a[22:0]};
    mb     = {(eb_raw != 8'd0), bus.in_b[22:0]};

    // Exponent and fraction together order the magnitudes; ties keep A first.
    s1_swap_d = (bus.in_a[30:0] < bus.in_b[30:0]);

    if (s1_swap_d) begin
      s1_big_sign_d   = bus.in_b[31];
      s1_small_sign_d = bus.in_a[31];
      s1_exp_d        = eb_eff;
      s1_small_exp_d  = ea_eff;
      s1_big_mant_d   = mb;
      s1_small_mant_d = ma;
    end else begin
      s1_big_sign_d   = bus.in_a[31];
      s1_small_sign_d = bus.in_b[31];
      s1_exp_d        = ea_eff;
      s1_small_exp_d  = eb_eff;
      s1_big_mant_d   = ma;
      s1_small_mant_d = mb;
    end

    // Two's-complement subtract; never negative once the operands are ordered.
    s1_diff_d    = s1_exp_d + (~s1_small_exp_d + 8'd1);
    s1_special_d = (&ea_raw) || (&eb_raw);
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic        s1_big_sign_q, s1_small_sign_q;
  logic [7:0]  s1_exp_q;
  logic [7:0]  s1_diff_q;
  logic [23:0] s1_big_mant_q, s1_small_mant_q;
  logic        s1_swap_q;
  logic        s1_special_q;

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: alignment shift with sticky collection
  // ---------------------------------------------------------------------------
  logic [4:0]  sh;
  logic [26:0] ext;
  logic [26:0] shifted;
  logic [26:0] lost_mask;
  logic        sticky;
  logic [26:0] s2_small_mant_d;

  always_comb begin
    // Any distance of 27 or more pushes every bit into the sticky position.
    sh        = (s1_diff_q >= 8'd27) ? 5'd27 : s1_diff_q[4:0];
    ext       = {s1_small_mant_q, 3'b000};
    shifted   = ext >> sh;
    lost_mask = ~({27{1'b1}} << sh);
    sticky    = |(ext & lost_mask);
    s2_small_mant_d = {shifted[26:1], shifted[0] | sticky};
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers (drive the outputs directly)
  // ---------------------------------------------------------------------------
  logic        s2_big_sign_q, s2_small_sign_q;
  logic [7:0]  s2_exp_q;
  logic [23:0] s2_big_mant_q;
  logic [26:0] s2_small_mant_q;
  logic        s2_swap_q;
  logic        s2_special_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q      <= 1'b0;
      s1_big_sign_q   <= 1'b0;
      s1_small_sign_q <= 1'b0;
      s1_exp_q        <= 8'd0;
      s1_diff_q       <= 8'd0;
      s1_big_mant_q   <= 24'd0;
      s1_small_mant_q <= 24'd0;
      s1_swap_q       <= 1'b0;
      s1_special_q    <= 1'b0;
      s2_valid_q      <= 1'b0;
      s2_big_sign_q   <= 1'b0;
      s2_small_sign_q <= 1'b0;
      s2_exp_q        <= 8'd0;
      s2_big_mant_q   <= 24'd0;
      s2_small_mant_q <= 27'd0;
      s2_swap_q       <= 1'b0;
      s2_special_q    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_big_sign_q   <= s1_big_sign_d;
          s1_small_sign_q <= s1_small_sign_d;
          s1_exp_q        <= s1_exp_d;
          s1_diff_q       <= s1_diff_d;
          s1_big_mant_q   <= s1_big_mant_d;
          s1_small_mant_q <= s1_small_mant_d;
          s1_swap_q       <= s1_swap_d;
          s1_special_q    <= s1_special_d;
        end
      end
      // Output fields only change when stage 2 advances, so they hold under stall.
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_big_sign_q   <= s1_big_sign_q;
          s2_small_sign_q <= s1_small_sign_q;
          s2_exp_q        <= s1_exp_q;
          s2_big_mant_q   <= s1_big_mant_q;
          s2_small_mant_q <= s2_small_mant_d;
          s2_swap_q       <= s1_swap_q;
          s2_special_q    <= s1_special_q;
        end
      end
    end
  end

  assign bus.out_valid      = s2_valid_q;
  assign bus.out_exp        = s2_exp_q;
  assign bus.out_big_sign   = s2_big_sign_q;
  assign bus.out_small_sign = s2_small_sign_q;
  assign bus.out_big_mant   = s2_big_mant_q;
  assign bus.out_small_mant = s2_small_mant_q;
  assign bus.out_swap       = s2_swap_q;
  assign bus.out_special    = s2_special_q;

endmodule

// File: tb/tb_fp_align_stage.sv
// -----------------------------------------------------------------------------
// tb_fp_align_stage
// Directed vectors for fp_align_stage. Result word layout used throughout:
// {exp[7:0], big_sign, small_sign, big_mant[23:0], small_mant[26:0], swap,
//  special} = 63 bits.
// -----------------------------------------------------------------------------
module tb_fp_align_stage;

  localparam int RW = 63;
  localparam int NV = 12;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  exp;
    logic        big_sign;
    logic        small_sign;
    logic [23:0] big_mant;
    logic [26:0] small_mant;
    logic        swap;
    logic        special;
  } vec_t;

  logic clk;
  logic rst;
  fp_align_if bus_if ();

  fp_align_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [RW-1:0] exp_q[$];
  vec_t          vecs[NV];

  function automatic logic [RW-1:0] pack_vec(input vec_t v);
    return {v.exp, v.big_sign, v.small_sign, v.big_mant, v.small_mant, v.swap, v.special};
  endfunction

  function automatic logic [RW-1:0] dut_word();
    return {bus_if.out_exp, bus_if.out_big_sign, bus_if.out_small_sign,
            bus_if.out_big_mant, bus_if.out_small_mant, bus_if.out_swap,
            bus_if.out_special};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: present a pair, wait (bounded) for in_ready, hand over on the edge.
  // Returns at posedge+1 after the accepting edge.
  // ---------------------------------------------------------------------------
  task automatic send(input vec_t v, input bit expect_out, output int waited);
    waited = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_a     = v.a;
    bus_if.in_b     = v.b;
    while (!bus_if.in_ready && waited <= 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited > 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      @(posedge clk);
      if (expect_out) exp_q.push_back(pack_vec(v));
    end
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor: compare every accepted result, and verify outputs
  // hold still while stalled.
  // ---------------------------------------------------------------------------
  logic          prev_stalled;
  logic [RW-1:0] prev_word;

  always @(negedge clk) begin
    if (rst) begin
      prev_stalled = 1'b0;
    end else begin
      if (prev_stalled) begin
        check("stall_hold_valid", {62'd0, bus_if.out_valid}, {62'd0, 1'b1});
        check("stall_hold_data", dut_word(), prev_word);
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h expected none", dut_word());
        end else begin
          check("result", dut_word(), exp_q.pop_front());
        end
      end
      prev_stalled = bus_if.out_valid && !bus_if.out_ready;
      prev_word    = dut_word();
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", RW'(exp_q.size()), RW'(0));
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int w;

    //             a             b             exp    bs    ss    big_mant    small_mant    sw    sp
    vecs[0]  = '{32'h3F800000, 32'h3F000000, 8'h7F, 1'b0, 1'b0, 24'h800000, 27'h2000000, 1'b0, 1'b0};
    vecs[1]  = '{32'h3F000000, 32'h40000000, 8'h80, 1'b0, 1'b0, 24'h800000, 27'h1000000, 1'b1, 1'b0};
    // d = 48: only sticky survives
    vecs[2]  = '{32'h4B800000, 32'h33800001, 8'h97, 1'b0, 1'b0, 24'h800000, 27'h0000001, 1'b0, 1'b0};
    // d = 25: {0xC00001,000} >> 25 = 3, lost bit 3 sets S
    vecs[3]  = '{32'h4B800000, 32'h3F400001, 8'h97, 1'b0, 1'b0, 24'h800000, 27'h0000003, 1'b0, 1'b0};
    // d = 4: only sticky distinguishes the lost LSB
    vecs[4]  = '{32'h3F800000, 32'h3D800001, 8'h7F, 1'b0, 1'b0, 24'h800000, 27'h0400001, 1'b0, 1'b0};
    // Inf vs denormal
    vecs[5]  = '{32'h7F800000, 32'h00000001, 8'hFF, 1'b0, 1'b0, 24'h800000, 27'h0000001, 1'b0, 1'b1};
    // equal magnitude, opposite signs: no swap
    vecs[6]  = '{32'hBF800000, 32'h3F800000, 8'h7F, 1'b1, 1'b0, 24'h800000, 27'h4000000, 1'b0, 1'b0};
    // two denormals, effective exponent 1
    vecs[7]  = '{32'h00000003, 32'h00000001, 8'h01, 1'b0, 1'b0, 24'h000003, 27'h0000008, 1'b0, 1'b0};
    // d = 27 exactly
    vecs[8]  = '{32'h0E000000, 32'h00800000, 8'h1C, 1'b0, 1'b0, 24'h800000, 27'h0000001, 1'b0, 1'b0};
    // d = 24: hidden bit lands in G
    vecs[9]  = '{32'h0C800000, 32'h00800000, 8'h19, 1'b0, 1'b0, 24'h800000, 27'h0000004, 1'b0, 1'b0};
    // negative larger B
    vecs[10] = '{32'h3F000000, 32'hC0000000, 8'h80, 1'b1, 1'b0, 24'h800000, 27'h1000000, 1'b1, 1'b0};
    // NaN B: d = 128, swap
    vecs[11] = '{32'h3F800000, 32'h7FC00000, 8'hFF, 1'b0, 1'b0, 24'hC00000, 27'h0000001, 1'b1, 1'b1};

    bus_if.in_valid  = 1'b0;
    bus_if.in_a      = 32'd0;
    bus_if.in_b      = 32'd0;
    bus_if.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset_out_valid", RW'(bus_if.out_valid), RW'(0));
    check("reset_in_ready", RW'(bus_if.in_ready), RW'(1));
    check("reset_data", dut_word(), RW'(0));

    // Latency: single pair, out_valid exactly one edge after s1 loads
    send(vecs[0], 1'b1, w);
    check("latency_s1_only", RW'(bus_if.out_valid), RW'(0));
    @(posedge clk); #1;
    check("latency_out_valid", RW'(bus_if.out_valid), RW'(1));
    drain();

    // Table, back to back at full throughput
    for (int i = 0; i < NV; i++) begin
      send(vecs[i], 1'b1, w);
      check($sformatf("throughput_wait_%0d", i), RW'(w), RW'(0));
    end
    drain();

    // Stall: 4 pairs with out_ready low for 3 cycles
    bus_if.out_ready = 1'b0;
    send(vecs[1], 1'b1, w);
    send(vecs[3], 1'b1, w);
    check("stall_in_ready_low", RW'(bus_if.in_ready), RW'(0));
    fork
      begin
        send(vecs[4], 1'b1, w);
        send(vecs[5], 1'b1, w);
      end
      begin
        @(posedge clk);
        #2 bus_if.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full: nothing from them may ever appear
    bus_if.out_ready = 1'b0;
    send(vecs[6], 1'b0, w);
    send(vecs[7], 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_out_valid", RW'(bus_if.out_valid), RW'(0));
    check("midreset_in_ready", RW'(bus_if.in_ready), RW'(1));
    check("midreset_out_exp", RW'(bus_if.out_exp), RW'(0));
    bus_if.out_ready = 1'b1;

    // Reset together with a presented pair: that pair is dropped
    rst = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_a = vecs[8].a;
    bus_if.in_b = vecs[8].b;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("no_stale_%0d", c), RW'(bus_if.out_valid), RW'(0));
      @(posedge clk); #1;
    end

    // Pipeline still works afterwards
    send(vecs[2], 1'b1, w);
    send(vecs[11], 1'b1, w);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
